// File: rtl/apb5_completer_regs_if.sv
// APB5 completer-side bus bundle: requester drives the request/user fields,
// the completer returns ready, read data, error, user echo and the sticky violation flag.
interface apb5_if #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 4,
    parameter int USER_DATA_WIDTH = 8,
    parameter int USER_RESP_WIDTH = 2
);
    logic                       psel;
    logic                       penable;
    logic [ADDR_WIDTH-1:0]      paddr;
    logic                       pwrite;
    logic [DATA_WIDTH-1:0]      pwdata;
    logic [DATA_WIDTH/8-1:0]    pstrb;
    logic [2:0]                 pprot;
    logic [USER_REQ_WIDTH-1:0]  pauser;
    logic [USER_DATA_WIDTH-1:0] pwuser;
    logic                       pready;
    logic [DATA_WIDTH-1:0]      prdata;
    logic                       pslverr;
    logic [USER_DATA_WIDTH-1:0] pruser;
    logic [USER_RESP_WIDTH-1:0] pbuser;
    logic                       proto_err;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pauser, pwuser,
        input  pready, prdata, pslverr, pruser, pbuser, proto_err
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pauser, pwuser,
        output pready, prdata, pslverr, pruser, pbuser, proto_err
    );
endinterface

// File: rtl/apb5_completer_regs.sv
// APB5 completer with a word-addressed register file, byte strobes, a secure-write register 0,
// programmable wait states, user-tag storage/echo and a sticky protocol-violation flag.
module apb5_completer_regs #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int WAIT_STATES     = 0,
    parameter int USER_REQ_WIDTH  = 4,
    parameter int USER_DATA_WIDTH = 8,
    parameter int USER_RESP_WIDTH = 2
) (
    input logic  pclk,
    input logic  presetn,
    apb5_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       proto_err_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       write_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [NB-1:0]              strb_q;
    logic                       err_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [USER_DATA_WIDTH-1:0] ruser_q;
    logic [USER_RESP_WIDTH-1:0] buser_q;

    logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
    logic [USER_DATA_WIDTH-1:0] tags_q [NUM_REGS];

    logic                  setup, access_ok, pready, capture, commit, proto_set, setup_err;
    logic [ADDR_WIDTH-3:0] setup_idx;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  unused_bits;

    assign setup     = bus.psel & ~bus.penable;
    assign access_ok = bus.psel & bus.penable;
    assign pready    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign setup_idx = bus.paddr[ADDR_WIDTH-1:2];
    assign rd_idx    = bus.paddr[IDX_W+1:2];
    assign wr_idx    = addr_q[IDX_W+1:2];
    // pprot[1] is the only protection bit that matters; pauser is echoed only in its low bits.
    assign unused_bits = ^{bus.pprot, bus.pauser};

    assign setup_err = (32'(setup_idx) >= NUM_REGS)
                     | (bus.paddr[1:0] != 2'b00)
                     | (!bus.pwrite && bus.pstrb != '0)
                     | (bus.pwrite && setup_idx == '0 && bus.pprot[1]);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        commit    = 1'b0;
        proto_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                    capture = 1'b1;
                end else if (access_ok) begin
                    proto_set = 1'b1;
                end
            end
            ACCESS: begin
                if (!access_ok) begin
                    proto_set = 1'b1;
                    state_d   = IDLE;
                end else begin
                    if (bus.paddr != addr_q || bus.pwrite != write_q ||
                        bus.pwdata != wdata_q || bus.pstrb != strb_q)
                        proto_set = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        commit  = write_q & ~err_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_q | proto_set;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ruser_q <= '0;
            buser_q <= '0;
        end else if (capture) begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            strb_q  <= bus.pstrb;
            err_q   <= setup_err;
            rdata_q <= (!setup_err && !bus.pwrite) ? regs_q[rd_idx] : '0;
            ruser_q <= (!setup_err && !bus.pwrite) ? tags_q[rd_idx] : '0;
            buser_q <= bus.pauser[USER_RESP_WIDTH-1:0];
        end
    end

    // NOTE: the register file is reset because its contents are architecturally defined as 0 after reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                tags_q[r] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < NB; b++)
                if (strb_q[b]) regs_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            if (strb_q != '0) tags_q[wr_idx] <= bus.pwuser;
        end
    end

    // Response fields are gated so they read 0 everywhere except the completion cycle.
    assign bus.pready    = pready;
    assign bus.prdata    = pready ? rdata_q : '0;
    assign bus.pruser    = pready ? ruser_q : '0;
    assign bus.pbuser    = pready ? buser_q : '0;
    assign bus.pslverr   = pready & err_q;
    assign bus.proto_err = proto_err_q;
endmodule
